// File: rtl/ddr_rst_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rst_supervisor
// Summary  : DDR2 controller reset sequencer with calibration watchdog,
//            settle filter and bounded retry of failed calibration attempts.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_rst_supervisor #(
    parameter logic [15:0] HOLD_CYCLES   = 16'd200,
    parameter logic [31:0] CAL_TIMEOUT   = 32'd40_000_000,
    parameter logic [7:0]  SETTLE_CYCLES = 8'd64,
    parameter logic [2:0]  MAX_RETRIES   = 3'd3
) (
    input  logic       ddr_sys_clk_200_o,
    input  logic       async_rst,
    input  logic       ddr_sys_rst_i,
    input  logic       calib_done_i,
    input  logic       restart_i,
    output logic       mig_sys_rst_n_o,
    output logic       ddr_ready_o,
    output logic       ddr_fail_o,
    output logic [2:0] retry_cnt_o
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_hold     = 3'd1;
    localparam logic [2:0] c_wait_cal = 3'd2;
    localparam logic [2:0] c_settle   = 3'd3;
    localparam logic [2:0] c_ready    = 3'd4;
    localparam logic [2:0] c_fail     = 3'd5;

    localparam logic [31:0] c_hold_last   = {16'd0, HOLD_CYCLES} - 32'd1;
    localparam logic [31:0] c_cal_last    = CAL_TIMEOUT - 32'd1;
    localparam logic [7:0]  c_settle_last = SETTLE_CYCLES - 8'd1;

    logic [1:0]  r_cal_sync;
    logic        w_cal_s;
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [7:0]  r_scnt;
    logic [7:0]  w_scnt_nxt;
    logic [2:0]  r_retry;
    logic [2:0]  w_retry_nxt;
    logic        w_attempt_fail;
    logic        r_mig_rst_n;
    logic        r_ready;
    logic        r_fail;

    // calib_done_i comes from the controller's own clock tree
    always_ff @(posedge ddr_sys_clk_200_o or posedge async_rst) begin
        if (async_rst) begin
            r_cal_sync <= 2'b00;
        end else begin
            r_cal_sync <= {r_cal_sync[0], calib_done_i};
        end
    end

    assign w_cal_s = r_cal_sync[1];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_scnt_nxt     = r_scnt;
        w_retry_nxt    = r_retry;
        w_attempt_fail = 1'b0;
        if (ddr_sys_rst_i) begin
            w_state_nxt = c_idle;
            w_cnt_nxt   = 32'd0;
            w_scnt_nxt  = 8'd0;
            w_retry_nxt = 3'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    w_state_nxt = c_hold;
                    w_cnt_nxt   = 32'd0;
                end
                c_hold: begin
                    if (r_cnt == c_hold_last) begin
                        w_state_nxt = c_wait_cal;
                        w_cnt_nxt   = 32'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                c_wait_cal: begin
                    // success wins over a timeout landing on the same cycle
                    if (w_cal_s) begin
                        w_state_nxt = c_settle;
                        w_scnt_nxt  = 8'd0;
                    end else if (r_cnt == c_cal_last) begin
                        w_attempt_fail = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                c_settle: begin
                    // cnt is kept so the watchdog spans the whole attempt
                    if (!w_cal_s) begin
                        w_state_nxt = c_wait_cal;
                    end else if (r_scnt == c_settle_last) begin
                        w_state_nxt = c_ready;
                    end else begin
                        w_scnt_nxt = r_scnt + 8'd1;
                    end
                end
                c_ready: begin
                    if (!w_cal_s) begin
                        w_attempt_fail = 1'b1;
                    end else if (restart_i) begin
                        w_state_nxt = c_hold;
                        w_cnt_nxt   = 32'd0;
                        w_retry_nxt = 3'd0;
                    end
                end
                c_fail: begin
                    if (restart_i) begin
                        w_state_nxt = c_hold;
                        w_cnt_nxt   = 32'd0;
                        w_retry_nxt = 3'd0;
                    end
                end
                default: begin
                    w_state_nxt = c_idle;
                    w_cnt_nxt   = 32'd0;
                    w_scnt_nxt  = 8'd0;
                end
            endcase

            if (w_attempt_fail) begin
                w_retry_nxt = r_retry + 3'd1;
                w_cnt_nxt   = 32'd0;
                w_state_nxt = (r_retry < MAX_RETRIES) ? c_hold : c_fail;
            end
        end
    end

    // outputs are decoded from the state being entered so they switch with it
    always_ff @(posedge ddr_sys_clk_200_o or posedge async_rst) begin
        if (async_rst) begin
            r_state     <= c_idle;
            r_cnt       <= 32'd0;
            r_scnt      <= 8'd0;
            r_retry     <= 3'd0;
            r_mig_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_scnt      <= w_scnt_nxt;
            r_retry     <= w_retry_nxt;
            r_mig_rst_n <= (w_state_nxt == c_wait_cal) || (w_state_nxt == c_settle) ||
                           (w_state_nxt == c_ready);
            r_ready     <= (w_state_nxt == c_ready);
            r_fail      <= (w_state_nxt == c_fail);
        end
    end

    assign mig_sys_rst_n_o = r_mig_rst_n;
    assign ddr_ready_o     = r_ready;
    assign ddr_fail_o      = r_fail;
    assign retry_cnt_o     = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rst_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ddr_rst_supervisor
// Summary  : Self-checking bench for ddr_rst_supervisor with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_rst_supervisor;

    localparam logic [15:0] HOLD = 16'd4;
    localparam logic [31:0] TMO  = 32'd20;
    localparam logic [7:0]  SETL = 8'd3;
    localparam logic [2:0]  MAXR = 3'd2;

    logic       clk       = 1'b0;
    logic       async_rst = 1'b1;
    logic       sys_rst   = 1'b1;
    logic       calib     = 1'b0;
    logic       restart   = 1'b0;
    logic       mig_n;
    logic       ready;
    logic       fail;
    logic [2:0] retry;
    logic [5:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs = {mig_n, ready, fail, retry};

    ddr_rst_supervisor #(
        .HOLD_CYCLES  (HOLD),
        .CAL_TIMEOUT  (TMO),
        .SETTLE_CYCLES(SETL),
        .MAX_RETRIES  (MAXR)
    ) u_dut (
        .ddr_sys_clk_200_o(clk),
        .async_rst        (async_rst),
        .ddr_sys_rst_i    (sys_rst),
        .calib_done_i     (calib),
        .restart_i        (restart),
        .mig_sys_rst_n_o  (mig_n),
        .ddr_ready_o      (ready),
        .ddr_fail_o       (fail),
        .retry_cnt_o      (retry)
    );

    // Reference model: phases with countdowns of remaining cycles/budget
    localparam int P_IDLE = 0, P_HOLD = 1, P_WAIT = 2, P_SETTLE = 3, P_READY = 4, P_FAIL = 5;
    int m_phase  = P_IDLE;
    int m_left   = 0;
    int m_budget = 0;
    int m_fails  = 0;
    bit m_s1     = 1'b0;
    bit m_s2     = 1'b0;

    task automatic m_begin_attempt();
        m_phase  = P_HOLD;
        m_left   = int'(HOLD);
        m_budget = int'(TMO);
    endtask

    task automatic m_attempt_failed();
        m_fails++;
        if (m_fails > int'(MAXR)) m_phase = P_FAIL;
        else m_begin_attempt();
    endtask

    task automatic m_step();
        bit cal;
        cal  = m_s2;
        m_s2 = m_s1;
        m_s1 = calib;
        if (sys_rst) begin
            m_phase = P_IDLE;
            m_fails = 0;
        end else begin
            case (m_phase)
                P_IDLE: m_begin_attempt();
                P_HOLD: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (cal) begin
                        m_phase = P_SETTLE;
                        m_left  = int'(SETL);
                    end else begin
                        m_budget--;
                        if (m_budget == 0) m_attempt_failed();
                    end
                end
                P_SETTLE: begin
                    if (!cal) m_phase = P_WAIT;
                    else begin
                        m_left--;
                        if (m_left == 0) m_phase = P_READY;
                    end
                end
                P_READY: begin
                    if (!cal) m_attempt_failed();
                    else if (restart) begin
                        m_fails = 0;
                        m_begin_attempt();
                    end
                end
                P_FAIL: begin
                    if (restart) begin
                        m_fails = 0;
                        m_begin_attempt();
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    function automatic logic [5:0] m_exp();
        logic [5:0] v;
        v[5]   = (m_phase == P_WAIT) || (m_phase == P_SETTLE) || (m_phase == P_READY);
        v[4]   = (m_phase == P_READY);
        v[3]   = (m_phase == P_FAIL);
        v[2:0] = 3'(m_fails);
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge async_rst);
            if (async_rst) begin
                m_phase = P_IDLE;
                m_fails = 0;
                m_s1    = 1'b0;
                m_s2    = 1'b0;
            end else begin
                m_step();
            end
        end
    end

    task automatic test_reset();
        async_rst = 1'b1;
        sys_rst   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, 6'b000000);
        end
        async_rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL reset_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
        end
    endtask

    task automatic test_nominal();
        int low;
        int lat;
        bit done;
        low = 0; lat = 0; done = 1'b0;
        calib   = 1'b0;
        sys_rst = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL nominal_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
            if (mig_n) done = 1'b1;
            else low++;
        end
        checks++;
        if (!done || low != 4) begin
            errors++;
            $display("FAIL nominal_mig_low got=%0d exp=4", low);
        end
        repeat (4) @(negedge clk);
        calib = 1'b1;
        done  = 1'b0;
        // ready-low cycles counted after the edge that first samples calib
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL nominal_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
            if (ready) done = 1'b1;
            else lat++;
        end
        checks++;
        if (!done || lat != 5) begin
            errors++;
            $display("FAIL nominal_ready_latency got=%0d exp=5", lat);
        end
        checks++;
        if (retry !== 3'd0) begin
            errors++;
            $display("FAIL nominal_retry got=%0d exp=0", retry);
        end
    endtask

    task automatic test_loss();
        int n;
        int low;
        bit done;
        n = 0; low = 0; done = 1'b0;
        calib = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            n++;
            calib = 1'b1;
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL loss_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
            if (!ready) done = 1'b1;
        end
        checks++;
        if (!done || n != 3) begin
            errors++;
            $display("FAIL loss_ready_fall got=%0d exp=3", n);
        end
        for (int i = 0; i < 20 && !mig_n; i++) begin
            low++;
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL loss_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
        end
        checks++;
        if (low != 4) begin
            errors++;
            $display("FAIL loss_mig_low got=%0d exp=4", low);
        end
        checks++;
        if (retry !== 3'd1) begin
            errors++;
            $display("FAIL loss_retry got=%0d exp=1", retry);
        end
        for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL loss_ready_again got=%b exp=1", ready);
        end
    endtask

    task automatic test_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL restart_ready got=%b exp=%b", obs, 6'b000000);
        end
        for (int i = 0; i < 30 && !ready; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL restart_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
        end
        // loss and restart seen together: the loss wins
        calib = 1'b0;
        @(negedge clk);
        calib = 1'b1;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL restart_vs_loss got=%b exp=%b", obs, 6'b000001);
        end
        for (int i = 0; i < 30 && !ready; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL restart_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
        end
    endtask

    task automatic test_sys_rst();
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL sysrst_in_ready got=%b exp=%b", obs, 6'b000000);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL sysrst_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
        end
    endtask

    task automatic test_glitch();
        int rise_at;
        int hi;
        bit c;
        rise_at = -1;
        calib   = 1'b0;
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 20 && !mig_n; i++) @(negedge clk);
        for (int i = 0; i < 40 && rise_at < 0; i++) begin
            c     = (i == 6) || (i == 7) || (i >= 9);
            calib = c;
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL glitch_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
            if (ready) rise_at = i;
        end
        checks++;
        if (rise_at != 14) begin
            errors++;
            $display("FAIL glitch_ready_at got=%0d exp=14", rise_at);
        end
        // same glitch, then calib stays low: watchdog must not restart
        calib   = 1'b0;
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 20 && !mig_n; i++) @(negedge clk);
        hi = 1;
        for (int i = 0; i < 60; i++) begin
            calib = (i == 6) || (i == 7);
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL glitch_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
            if (!mig_n) break;
            hi++;
        end
        checks++;
        if (hi != 23 || retry !== 3'd1) begin
            errors++;
            $display("FAIL glitch_timeout got=%0d/%0d exp=23/1", hi, retry);
        end
    endtask

    task automatic test_timeout();
        int n;
        int seen[$];
        logic [2:0] last;
        n = 0;
        calib   = 1'b0;
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        last = 3'd0;
        for (int i = 0; i < 200 && !fail; i++) begin
            @(negedge clk);
            n++;
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL timeout_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
            if (retry !== last) begin
                seen.push_back(int'(retry));
                last = retry;
            end
        end
        checks++;
        if (n != 73 || seen.size() != 3) begin
            errors++;
            $display("FAIL timeout_rounds got=%0d/%0d exp=73/3", n, seen.size());
        end else begin
            checks++;
            if (seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin
                errors++;
                $display("FAIL timeout_retry_seq got=%0d,%0d,%0d exp=1,2,3", seen[0], seen[1], seen[2]);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (obs !== 6'b001011) begin
            errors++;
            $display("FAIL timeout_fail_state got=%b exp=%b", obs, 6'b001011);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL timeout_restart got=%b exp=%b", obs, 6'b000000);
        end
    endtask

    task automatic test_async_mid();
        for (int i = 0; i < 20 && !mig_n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        async_rst = 1'b1;
        #1;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL async_mid got=%b exp=%b", obs, 6'b000000);
        end
        @(negedge clk);
        async_rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL async_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp()) begin
                errors++;
                $display("FAIL random_model t=%0t got=%b exp=%b", $time, obs, m_exp());
            end
            if ($urandom_range(0, 14) == 0) calib = ~calib;
            restart = ($urandom_range(0, 9) == 0);
            sys_rst = ($urandom_range(0, 249) == 0);
        end
        restart = 1'b0;
        sys_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_loss();
        test_restart();
        test_sys_rst();
        test_glitch();
        test_timeout();
        test_async_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
